// File: rtl/mipu_pkg.sv
// Shared definitions for the instruction-memory loader, IM and PCPU: IM geometry and loader FSM encodings.
package mipu_pkg;

  localparam int IM_ADDR_W          = 8;
  localparam int IM_DATA_W          = 16;
  localparam int LDR_BYTES_PER_WORD = 2;

  typedef enum logic [2:0] {
    LDR_IDLE = 3'd0,
    LDR_HDR  = 3'd1,
    LDR_HI   = 3'd2,
    LDR_LO   = 3'd3,
    LDR_WR   = 3'd4,
    LDR_CK   = 3'd5,
    LDR_DONE = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/im_byte_packer.sv
// Assembles big-endian byte pairs into IM words; with IM_LOADER_CKSUM_EN it also keeps a running XOR of payload bytes.
module im_byte_packer
  import mipu_pkg::*;
#(
  parameter int DATA_W = IM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              hi_en_i,
  input  logic              lo_en_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o
`ifdef IM_LOADER_CKSUM_EN
  ,
  output logic [7:0]        cksum_o
`endif
);

  localparam int BYTE_W = DATA_W / LDR_BYTES_PER_WORD;

  logic [BYTE_W-1:0] hi_q;
  logic [DATA_W-1:0] word_q;

  // The word register only changes when a low byte lands, so the IM data bus holds between writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      word_q <= '0;
    end else begin
      if (clr_i) begin
        hi_q <= '0;
      end else if (hi_en_i) begin
        hi_q <= byte_i[BYTE_W-1:0];
      end
      if (lo_en_i) begin
        word_q <= {hi_q, byte_i[BYTE_W-1:0]};
      end
    end
  end

  assign word_o = word_q;

`ifdef IM_LOADER_CKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xor_q <= 8'h00;
    end else if (clr_i) begin
      xor_q <= 8'h00;
    end else if (hi_en_i || lo_en_i) begin
      xor_q <= xor_q ^ byte_i;
    end
  end

  assign cksum_o = xor_q;
`endif

endmodule

// File: rtl/im_loader.sv
// Loads IM from a header+big-endian-word byte stream while holding the CPU in reset.
// Optional trailing XOR checksum byte when IM_LOADER_CKSUM_EN is defined.
// Byte handshake: a byte transfers on a rising edge where rx_valid & rx_ready are both 1;
// rx_ready is registered and high only in HDR, HI, LO and CK; rx_valid may stall indefinitely.
module im_loader
  import mipu_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DATA_W = IM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_din,
  output logic              im_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output ldr_state_e        dbg_state
);

  ldr_state_e        state_q;
  logic              rx_ready_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic              cpu_hold_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W:0]   words_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   wcnt_d;
  logic              accept;
  logic              start;
  logic              last_word;

  assign accept    = rx_valid & rx_ready_q;
  assign start     = load_start & ((state_q == LDR_IDLE) | (state_q == LDR_DONE));
  assign wcnt_d    = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (wcnt_d == words_q);

`ifdef IM_LOADER_CKSUM_EN
  logic       error_q;
  logic [7:0] cksum;
`endif

  im_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (start),
    .hi_en_i (accept && (state_q == LDR_HI)),
    .lo_en_i (accept && (state_q == LDR_LO)),
    .byte_i  (rx_data),
    .word_o  (im_din)
`ifdef IM_LOADER_CKSUM_EN
    ,
    .cksum_o (cksum)
`endif
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= LDR_IDLE;
      rx_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      words_q    <= '0;
      wcnt_q     <= '0;
`ifdef IM_LOADER_CKSUM_EN
      error_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        LDR_IDLE, LDR_DONE: begin
          if (load_start) begin
            state_q    <= LDR_HDR;
            rx_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            wcnt_q     <= '0;
`ifdef IM_LOADER_CKSUM_EN
            error_q    <= 1'b0;
`endif
          end
        end
        LDR_HDR: begin
          // A zero header means a full memory image.
          if (accept) begin
            words_q <= (rx_data == 8'd0) ? (ADDR_W+1)'(1 << ADDR_W) : (ADDR_W+1)'(rx_data);
            state_q <= LDR_HI;
          end
        end
        LDR_HI: begin
          if (accept) state_q <= LDR_LO;
        end
        LDR_LO: begin
          if (accept) begin
            state_q    <= LDR_WR;
            rx_ready_q <= 1'b0;
            im_we_q    <= 1'b1;
            im_addr_q  <= wcnt_q[ADDR_W-1:0];
          end
        end
        LDR_WR: begin
          im_we_q <= 1'b0;
          wcnt_q  <= wcnt_d;
          if (last_word) begin
`ifdef IM_LOADER_CKSUM_EN
            state_q    <= LDR_CK;
            rx_ready_q <= 1'b1;
`else
            state_q    <= LDR_DONE;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q    <= LDR_HI;
            rx_ready_q <= 1'b1;
          end
        end
`ifdef IM_LOADER_CKSUM_EN
        LDR_CK: begin
          if (accept) begin
            state_q    <= LDR_DONE;
            rx_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            error_q    <= (rx_data != cksum);
          end
        end
`endif
        default: state_q <= LDR_IDLE;
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
`ifdef IM_LOADER_CKSUM_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: expected IM writes queued per load, a negedge monitor checks every write and hold behaviour.
module tb_im_loader;
  import mipu_pkg::*;

`ifdef IM_LOADER_CKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  im_addr;
  logic [15:0] im_din;
  logic        im_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  ldr_state_e  dbg_state;

  im_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .im_addr    (im_addr),
    .im_din     (im_din),
    .im_we      (im_we),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];      // {addr, data} of each IM write the current load must produce
  logic [15:0] payload_q[$];
  logic [7:0]  last_addr;
  logic [15:0] last_din;
  logic [23:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      last_addr = 8'h00;
      last_din  = 16'h0000;
    end else begin
      check("hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
      if (im_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_we: got write addr %0h data %0h expected none", im_addr, im_din);
        end else begin
          mon_e = exp_q.pop_front();
          check("we_addr", {24'd0, im_addr}, {24'd0, mon_e[23:16]});
          check("we_data", {16'd0, im_din}, {16'd0, mon_e[15:0]});
        end
        check("ready_in_wr", {31'd0, rx_ready}, 32'd0);
        last_addr = im_addr;
        last_din  = im_din;
      end else begin
        check("addr_hold", {24'd0, im_addr}, {24'd0, last_addr});
        check("din_hold", {16'd0, im_din}, {16'd0, last_din});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = rx_ready;
      tick();
      n++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_timeout: byte %0h never accepted, expected acceptance", b);
    end
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_im_we"}, {31'd0, im_we}, 32'd0);
    check({tag, "_im_addr"}, {24'd0, im_addr}, 32'd0);
    check({tag, "_im_din"}, {16'd0, im_din}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, LDR_IDLE});
  endtask

  // Runs one load of payload_q; optional stall, mid-load start pulse, reset abort and bad checksum.
  task automatic run_load(input int gap_max, input int stall_word, input int poke_word,
                          input int abort_after, input bit bad_ck);
    int          n;
    logic [7:0]  ck;
    logic [15:0] w;
    logic [7:0]  addr_before;
    bit          exp_err;
    n  = payload_q.size();
    ck = 8'h00;
    for (int i = 0; i < n; i++) exp_q.push_back({8'(i), payload_q[i]});
    // A byte offered together with load_start must not be taken.
    load_start = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'hEE;
    tick();
    load_start = 1'b0;
    rx_valid   = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_done", {31'd0, done}, 32'd0);
    check("start_error", {31'd0, error}, 32'd0);
    check("start_ready", {31'd0, rx_ready}, 32'd1);
    send_byte((n == 256) ? 8'h00 : 8'(n), $urandom_range(0, gap_max));
    for (int i = 0; i < n; i++) begin
      w  = payload_q[i];
      ck = ck ^ w[15:8] ^ w[7:0];
      if (i == poke_word) begin
        addr_before = im_addr;
        load_start  = 1'b1;
        tick();
        load_start  = 1'b0;
        check("poke_busy", {31'd0, busy}, 32'd1);
        check("poke_addr", {24'd0, im_addr}, {24'd0, addr_before});
      end
      send_byte(w[15:8], $urandom_range(0, gap_max));
      send_byte(w[7:0], (i == stall_word) ? 10 : $urandom_range(0, gap_max));
      check("we_latency", {31'd0, im_we}, 32'd1);
      check("ready_low_wr", {31'd0, rx_ready}, 32'd0);
      if (i == abort_after) begin
        tick();
        check("abort_pending", exp_q.size(), n - 1 - i);
        reset = 1'b0;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        tick();
        reset = 1'b1;
        return;
      end
    end
    if (CK_ON) send_byte(bad_ck ? (ck ^ 8'h01) : ck, $urandom_range(0, gap_max));
    for (int k = 0; k < 10 && !done; k++) tick();
    exp_err = bad_ck & CK_ON;
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_hold", {31'd0, cpu_hold}, 32'd0);
    check("end_ready", {31'd0, rx_ready}, 32'd0);
    check("end_error", {31'd0, error}, {31'd0, exp_err});
    check("end_writes_left", exp_q.size(), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b1;
    tick();
    check_reset_values("post_reset");

    // Two words, back-to-back bytes.
    payload_q = '{16'h1234, 16'hABCD};
    run_load(0, -1, -1, -1, 1'b0);

    // Header 00 -> full 256-word image.
    payload_q.delete();
    for (int i = 0; i < 256; i++) payload_q.push_back(16'($urandom_range(0, 65535)));
    run_load(0, -1, -1, -1, 1'b0);
    check("full_last_addr", {24'd0, im_addr}, 32'h0000_00FF);

    // Ten-cycle stall before a low byte.
    payload_q = '{16'h0F0F, 16'hBEEF, 16'h5A5A};
    run_load(1, 1, -1, -1, 1'b0);

    // Reset after the third word of a five-word load.
    payload_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_load(0, -1, -1, 2, 1'b0);
    tick();

    // Checksum good then bad; checksum of 12 34 is 26.
    payload_q = '{16'h1234};
    check("ck_pin", {24'd0, payload_q[0][15:8] ^ payload_q[0][7:0]}, 32'h26);
    run_load(0, -1, -1, -1, 1'b0);
    run_load(0, -1, -1, -1, 1'b1);

    // load_start while busy is ignored.
    payload_q = '{16'hCAFE, 16'hF00D, 16'h0001, 16'h8000};
    run_load(0, -1, 2, -1, 1'b0);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      payload_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++)
        payload_q.push_back(16'($urandom_range(0, 65535)));
      run_load(3, -1, -1, -1, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
